// File: rtl/debounced_edge_detector.sv
// debounced_edge_detector
//
// Multi-channel input conditioner. Each raw asynchronous input is synchronised,
// optionally debounced, and turned into registered one-cycle rise/fall pulses
// plus a mode-selected edge pulse.
//
// Build option:
//   DEBOUNCE_EDGE_FILTER_EN  defined: per-channel debounce counters present; a new
//                            synchronised level must persist stable_cycles cycles.
//                            undefined: no counters; level follows the synchroniser
//                            with one register of delay and every change pulses.
//
// Parameters:
//   width          number of independent channels
//   sync_stages    synchroniser depth, 2..4
//   stable_cycles  debounce qualification length, >= 1
//   edge_mode      0 = rising, 1 = falling, anything else = both
//
// Ports:
//   clk_i              sole clock, rising edge
//   rst_i              synchronous active-high reset
//   signal_in          raw asynchronous inputs
//   level_out          accepted (debounced) level per channel
//   rise_pulse         one-cycle pulse on accepted 0->1
//   fall_pulse         one-cycle pulse on accepted 1->0
//   edge_detect_pulse  rise, fall or both, selected by edge_mode

module debounced_edge_detector #(
    parameter int unsigned width         = 1,
    parameter int unsigned sync_stages   = 2,
    parameter int unsigned stable_cycles = 16,
    parameter int unsigned edge_mode     = 0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [width-1:0] signal_in,
    output logic [width-1:0] level_out,
    output logic [width-1:0] rise_pulse,
    output logic [width-1:0] fall_pulse,
    output logic [width-1:0] edge_detect_pulse
);

    // Reject illegal configurations at elaboration.
    if (sync_stages < 2 || sync_stages > 4 || stable_cycles < 1) begin : g_bad_param
        $error("debounced_edge_detector: illegal sync_stages or stable_cycles");
    end

    // ------------------------------------------------------------------
    // Synchroniser: sync_q[0] samples the raw input, last stage is s.
    // ------------------------------------------------------------------
    logic [width-1:0] sync_q [sync_stages];
    logic [width-1:0] sync_d [sync_stages];
    logic [width-1:0] s;

    always_comb begin
        sync_d[0] = signal_in;
        for (int k = 1; k < int'(sync_stages); k++) begin
            sync_d[k] = sync_q[k-1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < int'(sync_stages); k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < int'(sync_stages); k++) begin
                sync_q[k] <= sync_d[k];
            end
        end
    end

    assign s = sync_q[sync_stages-1];

    // ------------------------------------------------------------------
    // Accepted level and registered pulses.
    // ------------------------------------------------------------------
    logic [width-1:0] lvl_q, lvl_d;
    logic [width-1:0] rise_q, rise_d;
    logic [width-1:0] fall_q, fall_d;

`ifdef DEBOUNCE_EDGE_FILTER_EN
    localparam int unsigned CntW = $clog2(stable_cycles + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(stable_cycles - 1);

    logic [CntW-1:0] cnt_q [width];
    logic [CntW-1:0] cnt_d [width];

    always_comb begin
        lvl_d  = lvl_q;
        rise_d = '0;
        fall_d = '0;
        for (int i = 0; i < int'(width); i++) begin
            cnt_d[i] = '0;
            if (s[i] != lvl_q[i]) begin
                if (cnt_q[i] == CntMax) begin
                    // Disagreement has persisted long enough: accept it.
                    lvl_d[i]  = s[i];
                    rise_d[i] = s[i];
                    fall_d[i] = ~s[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(width); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(width); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end
`else
    always_comb begin
        lvl_d  = s;
        rise_d = s & ~lvl_q;
        fall_d = ~s & lvl_q;
    end
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lvl_q  <= '0;
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            lvl_q  <= lvl_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    // Derived from registered pulses, so it is glitch-free and resets with them.
    always_comb begin
        edge_detect_pulse = rise_q | fall_q;
        case (edge_mode)
            0:       edge_detect_pulse = rise_q;
            1:       edge_detect_pulse = fall_q;
            default: edge_detect_pulse = rise_q | fall_q;
        endcase
    end

    assign level_out  = lvl_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;

endmodule
